// File: rtl/nios_cpu_led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, bit positions,
// FSM state encoding and the LEN clamp helper.
package nios_cpu_led_seq_pkg;

   localparam int MAX_ENTRIES = 8;

   localparam logic [3:0] ADDR_CTRL         = 4'd0;
   localparam logic [3:0] ADDR_STATUS       = 4'd1;
   localparam logic [3:0] ADDR_LEN          = 4'd2;
   localparam logic [3:0] ADDR_DIRECT       = 4'd3;
   localparam logic [3:0] ADDR_DWELL        = 4'd4;
   localparam logic [3:0] ADDR_PATTERN_BASE = 4'd8;

   localparam int CTRL_RUN    = 0;
   localparam int CTRL_LOOP   = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_DROP    = 2;
   localparam int STAT_IDX_LSB = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DWELL
   } seq_state_t;

   function automatic logic [2:0] clamp_len(input logic [2:0] len, input logic [2:0] last);
      return (len > last) ? last : len;
   endfunction

endpackage

// File: rtl/nios_cpu_led_seq_regs.sv
// CPU-facing register file of the LED sequencer: write decode, W1C status bits,
// zero-wait read mux and the pattern table read port used by the FSM.
module nios_cpu_led_seq_regs
   import nios_cpu_led_seq_pkg::*;
#(
   parameter int N_ENTRIES = 8,
   parameter int DWELL_W   = 24
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [3:0]         s_address,
   input  logic               s_chipselect,
   input  logic               s_write_n,
   input  logic [31:0]        s_writedata,
   output logic [31:0]        s_readdata,
   input  logic               busy,
   input  logic [2:0]         idx,
   input  logic               done_set,
   input  logic               run_clr,
   input  logic [2:0]         pat_idx,
   output logic [7:0]         pat_data,
   output logic               ctrl_wr,
   output logic               ctrl_wr_run,
   output logic               loop,
   output logic [2:0]         len,
   output logic [DWELL_W-1:0] dwell,
   output logic               direct_go,
   output logic               done_irq
);

   localparam logic [2:0] LAST_IDX = 3'(N_ENTRIES - 1);

   logic       run;
   logic       irq_en;
   logic       done;
   logic       drop_err;
   logic [7:0] direct;
   logic [7:0] pattern [MAX_ENTRIES];

   logic wr;
   logic status_wr;
   logic len_wr;
   logic dwell_wr;
   logic direct_wr;
   logic pat_wr;
   logic drop_set;
   logic unused_wdata;

   assign wr          = s_chipselect & ~s_write_n;
   assign ctrl_wr     = wr && (s_address == ADDR_CTRL);
   assign status_wr   = wr && (s_address == ADDR_STATUS);
   assign len_wr      = wr && (s_address == ADDR_LEN);
   assign direct_wr   = wr && (s_address == ADDR_DIRECT);
   assign dwell_wr    = wr && (s_address == ADDR_DWELL);
   assign pat_wr      = wr && s_address[3] && (s_address[2:0] <= LAST_IDX);
   assign ctrl_wr_run = s_writedata[CTRL_RUN];
   assign direct_go   = direct_wr && !busy;
   assign drop_set    = direct_wr && busy;
   assign done_irq    = done & irq_en;
   assign pat_data    = (pat_idx <= LAST_IDX) ? pattern[pat_idx] : 8'h00;
   assign unused_wdata = ^s_writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run      <= 1'b0;
         loop     <= 1'b0;
         irq_en   <= 1'b0;
         done     <= 1'b0;
         drop_err <= 1'b0;
         len      <= '0;
         direct   <= '0;
         dwell    <= '0;
         for (int i = 0; i < MAX_ENTRIES; i++) pattern[i] <= '0;
      end else begin
         // A CTRL write in the finishing cycle pre-empts the finish, so the two never collide.
         if (ctrl_wr) begin
            run    <= s_writedata[CTRL_RUN];
            loop   <= s_writedata[CTRL_LOOP];
            irq_en <= s_writedata[CTRL_IRQ_EN];
         end else if (run_clr) begin
            run <= 1'b0;
         end
         done     <= done_set | (done & ~(status_wr & s_writedata[STAT_DONE]));
         drop_err <= drop_set | (drop_err & ~(status_wr & s_writedata[STAT_DROP]));
         if (len_wr)    len    <= clamp_len(s_writedata[2:0], LAST_IDX);
         if (direct_go) direct <= s_writedata[7:0];
         if (dwell_wr)  dwell  <= s_writedata[DWELL_W-1:0];
         if (pat_wr)    pattern[s_address[2:0]] <= s_writedata[7:0];
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         ADDR_CTRL:   s_readdata[2:0] = {irq_en, loop, run};
         ADDR_STATUS: begin
            s_readdata[STAT_BUSY]            = busy;
            s_readdata[STAT_DONE]            = done;
            s_readdata[STAT_DROP]            = drop_err;
            s_readdata[STAT_IDX_LSB +: 3]    = idx;
         end
         ADDR_LEN:    s_readdata[2:0] = len;
         ADDR_DIRECT: s_readdata[7:0] = direct;
         ADDR_DWELL:  s_readdata[DWELL_W-1:0] = dwell;
         default: begin
            if (s_address[3] && (s_address[2:0] <= LAST_IDX))
               s_readdata[7:0] = pattern[s_address[2:0]];
         end
      endcase
   end

endmodule

// File: rtl/nios_cpu_led_sequencer.sv
// Avalon-MM LED sequencer: plays the pattern table onto the LED PIO with a
// programmable dwell, forwarding direct CPU writes only while idle.
module nios_cpu_led_sequencer
   import nios_cpu_led_seq_pkg::*;
#(
   parameter int N_ENTRIES = 8,
   parameter int DWELL_W   = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   output logic        done_irq
);

   localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

   seq_state_t         state;
   logic [2:0]         idx;
   logic [DWELL_W-1:0] cnt;

   logic               busy;
   logic               ctrl_wr;
   logic               ctrl_wr_run;
   logic               loop;
   logic [2:0]         len;
   logic [DWELL_W-1:0] dwell;
   logic               direct_go;
   logic [7:0]         pat_data;

   logic               cnt_expire;
   logic               last_step;
   logic               restart;
   logic               abort;
   logic               issue_go;
   logic               finish;
   logic [2:0]         issue_idx;
   logic [DWELL_W-1:0] dwell_load;

   nios_cpu_led_seq_regs #(
      .N_ENTRIES (N_ENTRIES),
      .DWELL_W   (DWELL_W)
   ) u_regs (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .busy         (busy),
      .idx          (idx),
      .done_set     (finish),
      .run_clr      (finish),
      .pat_idx      (issue_idx),
      .pat_data     (pat_data),
      .ctrl_wr      (ctrl_wr),
      .ctrl_wr_run  (ctrl_wr_run),
      .loop         (loop),
      .len          (len),
      .dwell        (dwell),
      .direct_go    (direct_go),
      .done_irq     (done_irq)
   );

   assign m_address = 2'b00;

   // CPU control writes take priority over dwell expiry (restart/abort win).
   always_comb begin
      busy       = (state != ST_IDLE);
      cnt_expire = (state == ST_DWELL) && (cnt == CNT_ONE);
      last_step  = (idx >= len);
      restart    = ctrl_wr && ctrl_wr_run;
      abort      = ctrl_wr && !ctrl_wr_run && busy;
      issue_go   = restart || (!ctrl_wr && cnt_expire && (!last_step || loop));
      finish     = !ctrl_wr && cnt_expire && last_step && !loop;
      issue_idx  = (restart || last_step) ? 3'd0 : idx + 3'd1;
      dwell_load = (dwell == '0) ? CNT_ONE : dwell;
   end

   // The PIO write is registered on entry to ISSUE, so the pulse coincides with that state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         idx          <= '0;
         cnt          <= '0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
      end else begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
         if (issue_go) begin
            state        <= ST_ISSUE;
            idx          <= issue_idx;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= {24'd0, pat_data};
         end else if (abort || finish) begin
            state <= ST_IDLE;
         end else if (direct_go) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= {24'd0, s_writedata[7:0]};
         end else if (state == ST_ISSUE) begin
            cnt   <= dwell_load;
            state <= ST_DWELL;
         end else if (state == ST_DWELL) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_nios_cpu_led_sequencer.sv
// Directed bench for the LED sequencer: register access, sequence timing,
// loop/abort, direct writes, dwell/len boundaries and mid-sequence reset.
module tb_nios_cpu_led_sequencer;

   localparam logic [3:0] A_CTRL   = 4'd0;
   localparam logic [3:0] A_STATUS = 4'd1;
   localparam logic [3:0] A_LEN    = 4'd2;
   localparam logic [3:0] A_DIRECT = 4'd3;
   localparam logic [3:0] A_DWELL  = 4'd4;
   localparam logic [3:0] A_PAT0   = 4'd8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  s_address;
   logic        s_chipselect;
   logic        s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        done_irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] pio_data [$];
   int          pio_cyc  [$];

   always #5 clk = ~clk;

   nios_cpu_led_sequencer #(
      .N_ENTRIES (4),
      .DWELL_W   (24)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .done_irq     (done_irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Record every PIO write with the cycle it was seen in.
   always @(negedge clk) begin
      if (m_chipselect && !m_write_n) begin
         pio_data.push_back(m_writedata);
         pio_cyc.push_back(cyc);
         check("m_address", 32'(m_address), 32'd0);
      end
   end

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, output int t);
      @(negedge clk);
      s_address    = a;
      s_writedata  = d;
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      t            = cyc;
      @(negedge clk);
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      s_address = a;
      #1;
      d = s_readdata;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic clear_log();
      pio_data.delete();
      pio_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      int          t;
      int          hits;
      logic [31:0] rd;
      logic [3:0]  rst_addrs [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
      logic [31:0] seq_exp  [5]  = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h01};

      reset_n      = 1'b0;
      s_address    = '0;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
      s_writedata  = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      check("rst_m_cs", 32'(m_chipselect), 32'd0);
      check("rst_m_wn", 32'(m_write_n), 32'd1);
      check("rst_m_wd", m_writedata, 32'd0);
      check("rst_irq", 32'(done_irq), 32'd0);
      for (int i = 0; i < 10; i++) begin
         bus_rd(rst_addrs[i], rd);
         check("rst_reg", rd, 32'd0);
      end

      // One-shot sequence, DWELL=4
      bus_wr(A_PAT0 + 4'd0, 32'h01, t);
      bus_wr(A_PAT0 + 4'd1, 32'h02, t);
      bus_wr(A_PAT0 + 4'd2, 32'h04, t);
      bus_wr(A_PAT0 + 4'd3, 32'h08, t);
      bus_wr(A_LEN, 32'd3, t);
      bus_wr(A_DWELL, 32'd4, t);
      bus_rd(A_PAT0 + 4'd2, rd);
      check("pat2_rd", rd, 32'h04);
      bus_rd(A_DWELL, rd);
      check("dwell_rd", rd, 32'd4);
      clear_log();
      bus_wr(A_CTRL, 32'h5, t);
      wait_cyc(t + 20);
      check("irq_before_done", 32'(done_irq), 32'd0);
      wait_cyc(t + 21);
      check("irq_at_done", 32'(done_irq), 32'd1);
      check("seq_count", 32'(pio_data.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < pio_data.size()) begin
            check("seq_data", pio_data[i], seq_exp[i]);
            check("seq_cyc", 32'(pio_cyc[i] - t), 32'(1 + 5 * i));
         end
      end
      bus_rd(A_STATUS, rd);
      check("seq_status", rd, 32'h32);
      bus_rd(A_CTRL, rd);
      check("seq_ctrl_run_clr", rd, 32'h4);
      bus_wr(A_STATUS, 32'h2, t);
      check("irq_w1c", 32'(done_irq), 32'd0);
      bus_rd(A_STATUS, rd);
      check("status_w1c", rd, 32'h30);

      // Looping sequence then abort mid-dwell
      clear_log();
      bus_wr(A_CTRL, 32'h7, t);
      wait_cyc(t + 22);
      bus_wr(A_CTRL, 32'h0, hits);
      repeat (30) @(negedge clk);
      check("loop_count", 32'(pio_data.size()), 32'd5);
      if (pio_data.size() >= 5) begin
         check("loop_wrap_data", pio_data[4], 32'h01);
         check("loop_wrap_cyc", 32'(pio_cyc[4] - t), 32'd21);
      end
      bus_rd(A_STATUS, rd);
      check("abort_status", rd, 32'h00);
      check("abort_irq", 32'(done_irq), 32'd0);

      // DIRECT while idle, then while busy
      clear_log();
      bus_wr(A_DIRECT, 32'hA5, t);
      repeat (3) @(negedge clk);
      check("direct_count", 32'(pio_data.size()), 32'd1);
      if (pio_data.size() >= 1) begin
         check("direct_data", pio_data[0], 32'h0000_00A5);
         check("direct_cyc", 32'(pio_cyc[0] - t), 32'd1);
      end
      clear_log();
      bus_wr(A_CTRL, 32'h3, t);
      bus_rd(A_STATUS, rd);
      check("busy_bit", rd & 32'h1, 32'h1);
      bus_wr(A_DIRECT, 32'h5A, t);
      repeat (8) @(negedge clk);
      bus_wr(A_CTRL, 32'h0, t);
      hits = 0;
      foreach (pio_data[i]) if (pio_data[i] == 32'h5A) hits++;
      check("drop_no_write", 32'(hits), 32'd0);
      bus_rd(A_STATUS, rd);
      check("drop_err_set", rd & 32'h7, 32'h4);
      bus_wr(A_STATUS, 32'h4, t);
      bus_rd(A_STATUS, rd);
      check("drop_err_w1c", rd & 32'h7, 32'h0);

      // DWELL=0 behaves as 1, LEN=1
      bus_wr(A_DWELL, 32'd0, t);
      bus_wr(A_LEN, 32'd1, t);
      clear_log();
      bus_wr(A_CTRL, 32'h1, t);
      repeat (10) @(negedge clk);
      check("d0_count", 32'(pio_data.size()), 32'd2);
      if (pio_data.size() >= 2) begin
         check("d0_data1", pio_data[1], 32'h02);
         check("d0_cyc0", 32'(pio_cyc[0] - t), 32'd1);
         check("d0_cyc1", 32'(pio_cyc[1] - t), 32'd3);
      end
      bus_rd(A_STATUS, rd);
      check("d0_status", rd, 32'h12);
      check("d0_irq_masked", 32'(done_irq), 32'd0);
      bus_wr(A_STATUS, 32'h2, t);

      // LEN=7 with 4 entries wraps after index 3
      bus_wr(A_DWELL, 32'd1, t);
      bus_wr(A_LEN, 32'd7, t);
      clear_log();
      bus_wr(A_CTRL, 32'h3, t);
      wait_cyc(t + 12);
      bus_wr(A_CTRL, 32'h0, hits);
      check("clamp_seen5", 32'(pio_data.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i < pio_data.size()) begin
            check("clamp_data", pio_data[i], seq_exp[i]);
            check("clamp_cyc", 32'(pio_cyc[i] - t), 32'(1 + 2 * i));
         end
      end

      // Reset mid-dwell
      bus_wr(A_DWELL, 32'd10, t);
      bus_wr(A_LEN, 32'd3, t);
      clear_log();
      bus_wr(A_CTRL, 32'h5, t);
      wait_cyc(t + 4);
      check("mid_started", 32'(pio_data.size()), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cs", 32'(m_chipselect), 32'd0);
      check("mid_rst_wn", 32'(m_write_n), 32'd1);
      check("mid_rst_wd", m_writedata, 32'd0);
      check("mid_rst_irq", 32'(done_irq), 32'd0);
      bus_rd(A_STATUS, rd);
      check("mid_rst_status", rd, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      clear_log();
      repeat (40) @(negedge clk);
      check("post_rst_quiet", 32'(pio_data.size()), 32'd0);
      bus_rd(A_PAT0, rd);
      check("post_rst_pat0", rd, 32'd0);
      bus_rd(A_CTRL, rd);
      check("post_rst_ctrl", rd, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nios_cpu_led_sequencer.md
# nios_cpu_led_sequencer

Avalon-MM controller that owns the green LED PIO's slave port and plays a programmable 8-entry pattern table onto it with a programmable per-step dwell. The Nios CPU configures it through its own slave port. Direct CPU LED writes are forwarded only when the sequencer is idle. The block sits between the CPU data master and the 8-bit LED output register, which no longer connects to the CPU directly.

## Interface
- N_ENTRIES, 8, pattern table depth; power of two, max 8.
- DWELL_W, 24, dwell counter width.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  4  CPU-side word address.
- s_chipselect  in  1  CPU-side select.
- s_write_n  in  1  CPU-side write strobe, active low.
- s_writedata  in  32  CPU-side write data.
- s_readdata  out  32  CPU-side read data, combinational from s_address, zero-wait.
- m_address  out  2  to LED PIO; always 0.
- m_chipselect  out  1  to LED PIO.
- m_write_n  out  1  to LED PIO, active low.
- m_writedata  out  32  to LED PIO; bits [31:8] always 0.
- done_irq  out  1  level interrupt, equal to STATUS.done & CTRL.irq_en.

## Operation
- Register map (word address):
  - 0 CTRL: bit0 run, bit1 loop, bit2 irq_en.
  - 1 STATUS (read): bit0 busy, bit1 done, bit2 drop_err, bits[6:4] idx. Writing 1 to bit1 or bit2 clears that bit.
  - 2 LEN: bits[2:0] = last entry index.
  - 3 DIRECT: bits[7:0].
  - 4 DWELL: bits[DWELL_W-1:0].
  - 8..15 PATTERN[0..7]: bits[7:0].
  - Unmapped reads return 0.
- FSM states IDLE, ISSUE, DWELL:
  - IDLE: a CTRL write with run=1 sets idx=0, busy=1, then goes to ISSUE.
  - ISSUE: for one cycle drives m_chipselect=1, m_write_n=0, m_writedata=PATTERN[idx]. Loads the dwell counter with max(DWELL,1), then goes to DWELL.
  - DWELL: decrements the counter each cycle. When the counter is 1:
    - If idx≠LEN: idx+1, go to ISSUE.
    - If idx=LEN and loop=1: idx=0, go to ISSUE.
    - If idx=LEN and loop=0: go to IDLE, busy=0, done=1, CTRL.run cleared.
- LEN greater than N_ENTRIES-1 is clamped to N_ENTRIES-1.
- DIRECT write in IDLE: next cycle issues one PIO write of the DIRECT value.
- DIRECT write while busy: dropped, and drop_err=1.
- Abort: a CTRL write with run=0 while busy returns to IDLE next cycle. No further PIO writes occur, done is not set, and the LED holds its last value.
- Restart: a CTRL write with run=1 while busy restarts from idx=0 with ISSUE next cycle.
- PATTERN, LEN, and DWELL writes while busy are legal. They take effect at the next ISSUE or counter load.

## Timing
- Reset values: all registers 0. m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, done_irq=0, state=IDLE.
- m_* outputs are registered and are pulses exactly one cycle wide. The PIO has no waitrequest, so each write completes in one cycle.
- Start latency: CTRL run write in cycle T gives the first PIO write in cycle T+1.
- Step period: consecutive PIO writes are DWELL+1 cycles apart; DWELL=0 behaves as DWELL=1.
- done is set in the cycle after the final dwell expires. done_irq is high from that cycle until done is cleared or irq_en=0.
- done set and a W1C clear in the same cycle: set wins.
- reset_n asserted mid-sequence: immediate return to reset values, with no partial write outstanding.

## Structure
- Package nios_cpu_led_seq_pkg holds:
  - register address constants (CTRL, STATUS, LEN, DIRECT, DWELL, PATTERN_BASE);
  - CTRL and STATUS bit indices;
  - the FSM state enum.
- One sub-module, nios_cpu_led_seq_regs: CPU register file, read mux, W1C logic.
- The top level holds the FSM, dwell counter, and master-port drive.

## Test plan
- Reset, then read all registers -> all 0; m_write_n=1, m_chipselect=0, done_irq=0.
- PATTERN[0..3]=0x01,0x02,0x04,0x08; LEN=3; DWELL=4; CTRL=0x5 -> PIO writes 01,02,04,08 spaced 5 cycles apart, first write 1 cycle after CTRL. Then busy=0, done=1, done_irq=1, CTRL.run=0. Writing STATUS=0x2 drops done_irq.
- Same setup with loop=1 -> after 08 the next write is 01, 5 cycles later. CTRL=0 written mid-dwell -> no further m_* pulses, done stays 0.
- DIRECT=0xA5 while idle -> one PIO write of 0x000000A5 next cycle. DIRECT=0x5A while busy -> no write, drop_err=1.
- DWELL=0, LEN=1 -> writes spaced 2 cycles apart. LEN=7 with N_ENTRIES=4 -> sequence wraps after idx 3.
- reset_n pulsed low during DWELL -> all outputs return to reset values at once, with no PIO write after release until a new run command.
